// File: rtl/w0rm_core_operand_fetch.sv
// Operand fetch: issues source register addresses to the register file,
// captures the returned data one cycle later and presents operands
// downstream. Register-file writes are snooped so operands waiting in the
// pipeline (or held at the output under back-pressure) never go stale.
module w0rm_core_operand_fetch #(
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_REGISTERS = 16,
    parameter  int OPCODE_WIDTH  = 8,
    localparam int REG_ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode,
    input  logic [REG_ADDR_BITS-1:0] in_rs0,
    input  logic [REG_ADDR_BITS-1:0] in_rs1,
    output logic [REG_ADDR_BITS-1:0] rf_read0_addr,
    input  logic [DATA_WIDTH-1:0]    rf_read0_data,
    output logic [REG_ADDR_BITS-1:0] rf_read1_addr,
    input  logic [DATA_WIDTH-1:0]    rf_read1_data,
    input  logic                     wb_enable,
    input  logic [REG_ADDR_BITS-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_WIDTH-1:0]  out_opcode,
    output logic [DATA_WIDTH-1:0]    out_op0,
    output logic [DATA_WIDTH-1:0]    out_op1
);

    // PEND stage: instruction whose register-file read is in flight
    logic                     pend_valid;
    logic [OPCODE_WIDTH-1:0]  pend_opcode;
    logic [REG_ADDR_BITS-1:0] pend_rs0;
    logic [REG_ADDR_BITS-1:0] pend_rs1;

    // OUT stage source addresses, kept so held operands can be refreshed
    logic [REG_ADDR_BITS-1:0] out_rs0;
    logic [REG_ADDR_BITS-1:0] out_rs1;

    logic                     out_free;
    logic                     accept;
    logic                     capture;
    logic                     hold;
    logic [DATA_WIDTH-1:0]    capture_op0;
    logic [DATA_WIDTH-1:0]    capture_op1;
    logic [DATA_WIDTH-1:0]    hold_op0;
    logic [DATA_WIDTH-1:0]    hold_op1;

    // Handshake decisions; in_ready deliberately ignores in_valid
    assign out_free = !out_valid || out_ready;
    assign in_ready = !pend_valid || out_free;
    assign accept   = in_valid && in_ready && !flush;
    assign capture  = pend_valid && out_free && !flush;
    assign hold     = out_valid && !out_ready && !flush;

    // A stalled PEND re-presents its addresses so the file output tracks writes
    assign rf_read0_addr = accept ? in_rs0 : pend_rs0;
    assign rf_read1_addr = accept ? in_rs1 : pend_rs1;

    // A write landing on the capture edge is not yet visible on the read data
    assign capture_op0 = (wb_enable && (wb_addr == pend_rs0)) ? wb_data : rf_read0_data;
    assign capture_op1 = (wb_enable && (wb_addr == pend_rs1)) ? wb_data : rf_read1_data;

    // Held operands pick up any write to their source register
    assign hold_op0 = (wb_enable && (wb_addr == out_rs0)) ? wb_data : out_op0;
    assign hold_op1 = (wb_enable && (wb_addr == out_rs1)) ? wb_data : out_op1;

    // PEND stage: load on accept, empty once its data moves to OUT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid  <= 1'b0;
            pend_opcode <= '0;
            pend_rs0    <= '0;
            pend_rs1    <= '0;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_valid  <= 1'b1;
            pend_opcode <= in_opcode;
            pend_rs0    <= in_rs0;
            pend_rs1    <= in_rs1;
        end else if (pend_valid && out_free) begin
            pend_valid <= 1'b0;
        end
    end

    // OUT valid: set on capture, cleared on drain or flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // OUT data: load on capture, refresh from snooped writes while held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_opcode <= '0;
            out_op0    <= '0;
            out_op1    <= '0;
            out_rs0    <= '0;
            out_rs1    <= '0;
        end else if (capture) begin
            out_opcode <= pend_opcode;
            out_rs0    <= pend_rs0;
            out_rs1    <= pend_rs1;
            out_op0    <= capture_op0;
            out_op1    <= capture_op1;
        end else if (hold) begin
            out_op0 <= hold_op0;
            out_op1 <= hold_op1;
        end
    end

endmodule

// File: tb/tb_w0rm_core_operand_fetch.sv
// Bench for w0rm_core_operand_fetch: a behavioural register file drives the
// read ports; a queue-based model predicts handshakes, and operands are
// expected to equal the architectural register contents at all times.
module tb_w0rm_core_operand_fetch;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int OW = 8;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_opcode;
    logic [AB-1:0] in_rs0;
    logic [AB-1:0] in_rs1;
    logic [AB-1:0] rf_read0_addr;
    logic [DW-1:0] rf_read0_data;
    logic [AB-1:0] rf_read1_addr;
    logic [DW-1:0] rf_read1_data;
    logic          wb_enable;
    logic [AB-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_opcode;
    logic [DW-1:0] out_op0;
    logic [DW-1:0] out_op1;

    always #5 clk = ~clk;

    w0rm_core_operand_fetch #(
        .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .OPCODE_WIDTH(OW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs0(in_rs0), .in_rs1(in_rs1),
        .rf_read0_addr(rf_read0_addr), .rf_read0_data(rf_read0_data),
        .rf_read1_addr(rf_read1_addr), .rf_read1_data(rf_read1_data),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_op0(out_op0), .out_op1(out_op1)
    );

    // Register file: registered read with same-edge write bypass
    logic [DW-1:0] regs [NR];
    always @(posedge clk) begin
        if (wb_enable) regs[wb_addr] <= wb_data;
        rf_read0_data <= (wb_enable && wb_addr == rf_read0_addr) ? wb_data : regs[rf_read0_addr];
        rf_read1_data <= (wb_enable && wb_addr == rf_read1_addr) ? wb_data : regs[rf_read1_addr];
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: in-order queue of in-flight instructions,
    // stage 1 = waiting for register data, stage 2 = presented downstream
    typedef struct {
        logic [OW-1:0] opcode;
        logic [AB-1:0] rs0;
        logic [AB-1:0] rs1;
        int            stage;
    } entry_t;
    entry_t q[$];
    bit     m_acc;

    task automatic model_check();
        bit has1, has2, exp_ready;
        int idx1;
        has1 = 0; idx1 = 0;
        foreach (q[i]) if (q[i].stage == 1) begin has1 = 1; idx1 = i; end
        has2 = (q.size() > 0) && (q[0].stage == 2);
        exp_ready = !has1 || !has2 || out_ready;
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, has2);
        if (has2) begin
            chk("out_opcode", out_opcode, q[0].opcode);
            chk("out_op0", out_op0, regs[q[0].rs0]);
            chk("out_op1", out_op1, regs[q[0].rs1]);
        end
        m_acc = in_valid && exp_ready && !flush;
        if (m_acc) begin
            chk("rf_addr0_acc", rf_read0_addr, in_rs0);
            chk("rf_addr1_acc", rf_read1_addr, in_rs1);
        end else if (has1) begin
            chk("rf_addr0_pend", rf_read0_addr, q[idx1].rs0);
            chk("rf_addr1_pend", rf_read1_addr, q[idx1].rs1);
        end
    endtask

    task automatic model_update();
        entry_t e;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].stage == 2 && out_ready) void'(q.pop_front());
            if (q.size() > 0 && q[0].stage == 1) q[0].stage = 2;
            if (m_acc) begin
                e.opcode = in_opcode; e.rs0 = in_rs0; e.rs1 = in_rs1; e.stage = 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit iv, input logic [OW-1:0] opc, input logic [AB-1:0] r0, input logic [AB-1:0] r1);
        in_valid = iv; in_opcode = opc; in_rs0 = r0; in_rs1 = r1;
    endtask

    typedef struct {
        bit            iv;
        logic [OW-1:0] opc;
        logic [AB-1:0] rs0;
        logic [AB-1:0] rs1;
        bit            ev;
        logic [OW-1:0] eopc;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;
    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 8'hA1, 4'd3, 4'd5, 1'b0, 8'h00, 32'h0, 32'h0};
        vt[1] = '{1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 8'h00, 32'h0, 32'h0};
        vt[2] = '{1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 8'hA1, 32'h11, 32'h22};
        vt[3] = '{1'b1, 8'hA2, 4'd5, 4'd3, 1'b0, 8'h00, 32'h0, 32'h0};
        vt[4] = '{1'b1, 8'hA3, 4'd1, 4'd2, 1'b0, 8'h00, 32'h0, 32'h0};
        vt[5] = '{1'b1, 8'hA4, 4'd3, 4'd3, 1'b1, 8'hA2, 32'h22, 32'h11};
        vt[6] = '{1'b1, 8'hA5, 4'd2, 4'd1, 1'b1, 8'hA3, 32'h1001, 32'h1002};
        vt[7] = '{1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 8'hA4, 32'h11, 32'h11};
        vt[8] = '{1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 8'hA5, 32'h1002, 32'h1001};
        vt[9] = '{1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 8'h00, 32'h0, 32'h0};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        #2 reset = 1'b0;

        // Preload the register file through the write port while in reset
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            wb_enable = 1'b1; wb_addr = AB'(i);
            wb_data = (i == 3) ? 32'h11 : (i == 5) ? 32'h22 : 32'h1000 + i;
        end
        @(negedge clk);
        wb_enable = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_opcode", out_opcode, 8'h00);
        chk("rst_out_op0", out_op0, 32'h0);
        chk("rst_out_op1", out_op1, 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rf_addr0", rf_read0_addr, 4'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic accept and 4-deep back-to-back stream
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b1;
            drive(vt[i].iv, vt[i].opc, vt[i].rs0, vt[i].rs1);
            neg();
            chk("tbl_valid", out_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk("tbl_opcode", out_opcode, vt[i].eopc);
                chk("tbl_op0", out_op0, vt[i].e0);
                chk("tbl_op1", out_op1, vt[i].e1);
            end
            edge_step();
        end

        // Held output refreshed by a write to its source register
        out_ready = 1'b0;
        drive(1'b1, 8'hB1, 4'd3, 4'd5); neg(); edge_step();
        drive(1'b0, '0, '0, '0); neg(); edge_step();
        neg();
        chk("hold_before_op0", out_op0, 32'h11);
        wb_enable = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD;
        edge_step();
        wb_enable = 1'b0; out_ready = 1'b1;
        neg();
        chk("hold_fwd_op0", out_op0, 32'hDEAD);
        chk("hold_fwd_op1", out_op1, 32'h22);
        chk("hold_deliver", out_valid, 1'b1);
        edge_step();
        neg(); edge_step();

        // PEND stalled behind a full OUT while its source is written
        out_ready = 1'b0;
        drive(1'b1, 8'hC1, 4'd1, 4'd2); neg(); edge_step();
        drive(1'b0, '0, '0, '0); neg(); edge_step();
        drive(1'b1, 8'hC2, 4'd3, 4'd7); neg(); edge_step();
        drive(1'b1, 8'hEE, 4'd4, 4'd4);
        wb_enable = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
        neg();
        chk("stall_in_ready", in_ready, 1'b0);
        edge_step();
        wb_enable = 1'b0; drive(1'b0, '0, '0, '0);
        neg();
        chk("stall_in_ready2", in_ready, 1'b0);
        edge_step();
        out_ready = 1'b1;
        neg(); edge_step();
        neg();
        chk("stall_opcode", out_opcode, 8'hC2);
        chk("stall_op1", out_op1, 32'h77);
        chk("stall_op0", out_op0, 32'hDEAD);
        edge_step();

        // Write on the exact capture edge, rs0 == rs1
        drive(1'b1, 8'hE9, 4'd9, 4'd9); neg(); edge_step();
        drive(1'b0, '0, '0, '0);
        wb_enable = 1'b1; wb_addr = 4'd9; wb_data = 32'h99;
        neg(); edge_step();
        wb_enable = 1'b0;
        neg();
        chk("cap_fwd_op0", out_op0, 32'h99);
        chk("cap_fwd_op1", out_op1, 32'h99);
        chk("cap_fwd_opcode", out_opcode, 8'hE9);
        edge_step();
        neg(); edge_step();

        // Flush with both stages occupied and a live input handshake
        out_ready = 1'b0;
        drive(1'b1, 8'hF1, 4'd1, 4'd1); neg(); edge_step();
        drive(1'b0, '0, '0, '0); neg(); edge_step();
        drive(1'b1, 8'hF2, 4'd2, 4'd2); neg(); edge_step();
        drive(1'b1, 8'hF3, 4'd3, 4'd3); out_ready = 1'b1; flush = 1'b1;
        neg(); edge_step();
        flush = 1'b0; drive(1'b0, '0, '0, '0);
        neg();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        edge_step();
        neg();
        chk("flush_no_f3", out_valid, 1'b0);
        edge_step();

        // Asynchronous reset mid-stream, then a fresh instruction
        out_ready = 1'b1;
        drive(1'b1, 8'h61, 4'd1, 4'd2); neg(); edge_step();
        drive(1'b1, 8'h62, 4'd2, 4'd1); neg(); edge_step();
        drive(1'b0, '0, '0, '0); neg();
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_op0", out_op0, 32'h0);
        chk("arst_op1", out_op1, 32'h0);
        chk("arst_opcode", out_opcode, 8'h00);
        chk("arst_in_ready", in_ready, 1'b1);
        q.delete();
        #1 reset = 1'b1;
        drive(1'b1, 8'h71, 4'd3, 4'd5);
        #1 model_check();
        edge_step();
        drive(1'b0, '0, '0, '0);
        neg();
        chk("post_rst_wait", out_valid, 1'b0);
        edge_step();
        neg();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_opcode", out_opcode, 8'h71);
        chk("post_rst_op0", out_op0, 32'hDEAD);
        chk("post_rst_op1", out_op1, 32'h22);
        edge_step();

        // Randomized traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            drive(($urandom % 4) != 0, OW'($urandom), AB'($urandom), AB'($urandom));
            out_ready = ($urandom % 3) != 0;
            wb_enable = $urandom % 2;
            wb_addr   = AB'($urandom);
            wb_data   = $urandom;
            flush     = ($urandom % 25) == 0;
            neg();
            edge_step();
        end
        drive(1'b0, '0, '0, '0);
        wb_enable = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            neg();
            edge_step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/w0rm_core_operand_fetch.md
Name: w0rm_core_operand_fetch

Overview:
- Initiator side of the core register file's read interface.
- Accepts decoded instructions over a valid/ready handshake and issues the two source register addresses to the register file's read ports.
- Captures the returned data one cycle later and presents the operands downstream over a second valid/ready handshake.
- Snoops the register-file write port so that operands held during a stall never go stale. Sits between the decode and execute stages.

Parameters:
DATA_WIDTH, 32, operand width; must match the register file.
NUM_REGISTERS, 16, register count; REG_ADDR_BITS = ceil(log2(NUM_REGISTERS)), a localparam.
OPCODE_WIDTH, 8, width of the opaque sideband carried alongside the operands.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  decoded instruction valid.
in_ready  out  1  block can accept this cycle.
in_opcode  in  OPCODE_WIDTH  sideband.
in_rs0  in  REG_ADDR_BITS  source register 0.
in_rs1  in  REG_ADDR_BITS  source register 1.
rf_read0_addr  out  REG_ADDR_BITS  to register file read port 0.
rf_read0_data  in  DATA_WIDTH  from read port 0; registered, 1-cycle latency, same-edge write bypass.
rf_read1_addr  out  REG_ADDR_BITS  to read port 1.
rf_read1_data  in  DATA_WIDTH  from read port 1.
wb_enable  in  1  snooped register file write enable.
wb_addr  in  REG_ADDR_BITS  snooped write address.
wb_data  in  DATA_WIDTH  snooped write data.
out_valid  out  1  operands valid.
out_ready  in  1  downstream accepts.
out_opcode  out  OPCODE_WIDTH  sideband.
out_op0  out  DATA_WIDTH  operand 0.
out_op1  out  DATA_WIDTH  operand 1.

Behaviour:
- Two stages:
  - PEND: pend_valid, pend_opcode, pend_rs0, pend_rs1.
  - OUT: out_valid, out_opcode, out_op0, out_op1, plus held out_rs0/out_rs1.
- out_free = !out_valid || out_ready.
- in_ready = !pend_valid || out_free. This is a combinational function of state and out_ready only, never of in_valid.
- accept = in_valid && in_ready && !flush.
- Address drive:
  - rf_readN_addr = in_rsN when accept, else pend_rsN.
  - While PEND stalls, its address is re-presented every cycle, so the register file output tracks later writes.
- PEND update on the edge:
  - accept sets pend_valid=1 and loads in_opcode/in_rs0/in_rs1.
  - Otherwise, if pend_valid && out_free, pend_valid=0.
- OUT capture: when pend_valid && out_free, OUT loads from PEND with opN = (wb_enable && wb_addr==pend_rsN) ? wb_data : rf_readN_data.
  - The forward covers a write landing on the capture edge that the register file output does not yet reflect.
  - out_valid=1 after capture.
- OUT hold:
  - If out_valid && !out_ready and no capture, opN is replaced by wb_data whenever wb_enable && wb_addr==out_rsN; otherwise it holds.
  - Both operands are forwarded independently. rs0==rs1 yields identical values.
- OUT drain: out_valid && out_ready with no capture sets out_valid=0.
- Latency:
  - in accept to out_valid = 2 edges.
  - Sustained throughput is 1 per cycle when out_ready stays high.
- Back-to-back with dependency: the block does no hazard detection. It forwards only architectural writes already on the wb port.
- flush:
  - Clears pend_valid and out_valid on the edge.
  - An input handshake in the flush cycle is discarded.
  - Data registers are unchanged.
  - flush beats every other event.
- Reset, asynchronous, reset==0:
  - pend_valid=0, out_valid=0.
  - out_opcode, out_op0, out_op1 = 0.
  - pend/out register addresses = 0.
  - Consequences: in_ready=1, rf_read*_addr = in_rs* (accept path) or 0.
  - Reset mid-transfer drops all in-flight instructions. Release is synchronous-deassert safe; the first accept is possible on the first edge after release.
- Data output registers change only on capture, hold forward, or reset.

Test Plan:
- Reg file preloaded r3=0x11, r5=0x22; accept {opcode 0xA1, rs0=3, rs1=5} with out_ready=1 -> out_valid after 2 edges with op0=0x11, op1=0x22, opcode 0xA1; stream of 4 back-to-back instructions -> 4 consecutive out_valid cycles.
- out_ready=0 holding r3 instruction, then wb write r3=0xDEAD -> out_op0 becomes 0xDEAD next edge, op1 unchanged; out_ready=1 delivers 0xDEAD.
- PEND stalled (OUT full, out_ready=0) on rs1=7, write r7=0x77 in stall, then release -> captured op1=0x77; in_ready=0 during the full stall.
- wb write r9=0x99 on the exact capture edge of an instruction with rs0=rs1=9 -> op0=op1=0x99.
- flush asserted with in_valid=1, PEND and OUT both occupied -> next cycle out_valid=0, pend empty, flushed-cycle input never appears.
- Assert reset low mid-stream (async, between edges) -> out_valid drops immediately, outputs 0; after release, a new instruction completes in 2 edges.
